// File: rtl/bcd_7seg_scan.sv
// Holds a packed 4-digit BCD value captured on load and scans it onto a
// multiplexed 7-segment display, with leading-zero blanking and '-' for non-BCD nibbles.
module bcd_7seg_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = (AN_ACT_LOW != 0) ? 4'hF : 4'h0;
    localparam logic       DP_OFF  = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;

    logic [15:0]      latch;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [3:0]       nib;
    logic             blank;
    logic [6:0]       seg_nxt;
    logic [3:0]       an_nxt;

    // Active-high segment pattern {g,f,e,d,c,b,a}; anything above 9 shows '-'.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] s);
        return (SEG_ACT_LOW != 0) ? ~s : s;
    endfunction

    function automatic logic [3:0] an_pol(input logic [3:0] a);
        return (AN_ACT_LOW != 0) ? ~a : a;
    endfunction

    // Capture and scan control; load never disturbs cnt/idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch <= 16'h0000;
            cnt   <= '0;
            idx   <= 2'd0;
        end else begin
            if (load)
                latch <= bcd;
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A digit is blank when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        nib   = latch[{idx, 2'b00} +: 4];
        blank = 1'b0;
        if (BLANK_LZ != 0) begin
            case (idx)
                2'd3:    blank = (latch[15:12] == 4'd0);
                2'd2:    blank = (latch[15:8] == 8'd0);
                2'd1:    blank = (latch[15:4] == 12'd0);
                default: blank = 1'b0;
            endcase
        end
        if (blank) begin
            seg_nxt = SEG_OFF;
            an_nxt  = AN_OFF;
        end else begin
            seg_nxt = seg_pol(decode(nib));
            an_nxt  = an_pol(4'b0001 << idx);
        end
    end

    // Registered display drive, one cycle behind idx/latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
        dp <= DP_OFF;
    end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan with REFRESH_DIV=4, active-low outputs, blanking on.
module tb_bcd_7seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] bcd = 16'h0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int compared = 0;
    int mismatched = 0;

    bcd_7seg_scan #(
        .REFRESH_DIV(4),
        .SEG_ACT_LOW(1),
        .AN_ACT_LOW (1),
        .BLANK_LZ   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .load(load),
        .bcd (bcd),
        .seg (seg),
        .dp  (dp),
        .an  (an)
    );

    always #5 clk = ~clk;

    // One cycle: sample on the falling edge, after the outputs registered on the rising edge.
    task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es);
        @(negedge clk);
        compared++;
        assert (an === ea) else begin
            mismatched++;
            $error("FAIL %s an: got %h, want %h", tag, an, ea);
        end
        compared++;
        assert (seg === es) else begin
            mismatched++;
            $error("FAIL %s seg: got %h, want %h", tag, seg, es);
        end
        compared++;
        assert (dp === 1'b1) else begin
            mismatched++;
            $error("FAIL %s dp: got %b, want 1", tag, dp);
        end
    endtask

    task automatic slot(input string tag, input logic [3:0] ea, input logic [6:0] es, input int n);
        for (int i = 0; i < n; i++)
            chk(tag, ea, es);
    endtask

    // Full slot whose final edge (the cnt wrap) also loads nv.
    task automatic slot_load(input string tag, input logic [3:0] ea, input logic [6:0] es,
                             input logic [15:0] nv, input bit hold);
        slot(tag, ea, es, 3);
        load = 1'b1;
        bcd  = nv;
        chk(tag, ea, es);
        if (!hold)
            load = 1'b0;
    endtask

    initial begin
        // Reset held for three edges
        slot("rst_hold", 4'hF, 7'h7F, 3);
        rst = 1'b0;
        slot("rst_d0", 4'hE, 7'h40, 4);
        slot("rst_d1", 4'hF, 7'h7F, 4);
        slot("rst_d2", 4'hF, 7'h7F, 4);
        slot_load("rst_d3", 4'hF, 7'h7F, 16'h1234, 1'b0);

        // Scan order, two full rounds
        slot("s1_d0", 4'hE, 7'h19, 4);
        slot("s1_d1", 4'hD, 7'h30, 4);
        slot("s1_d2", 4'hB, 7'h24, 4);
        slot("s1_d3", 4'h7, 7'h79, 4);
        slot("s2_d0", 4'hE, 7'h19, 4);
        slot("s2_d1", 4'hD, 7'h30, 4);
        slot("s2_d2", 4'hB, 7'h24, 4);
        slot_load("s2_d3", 4'h7, 7'h79, 16'h0255, 1'b0);

        // Leading-zero blanking
        slot("b255_d0", 4'hE, 7'h12, 4);
        slot("b255_d1", 4'hD, 7'h12, 4);
        slot("b255_d2", 4'hB, 7'h24, 4);
        slot_load("b255_d3", 4'hF, 7'h7F, 16'h0000, 1'b0);
        slot("b0_d0", 4'hE, 7'h40, 4);
        slot("b0_d1", 4'hF, 7'h7F, 4);
        slot("b0_d2", 4'hF, 7'h7F, 4);
        slot_load("b0_d3", 4'hF, 7'h7F, 16'h00A3, 1'b0);

        // Non-BCD nibble shows '-'
        slot("inv_d0", 4'hE, 7'h30, 4);
        slot("inv_d1", 4'hD, 7'h3F, 4);
        slot("inv_d2", 4'hF, 7'h7F, 4);
        slot_load("inv_d3", 4'hF, 7'h7F, 16'h0015, 1'b0);

        // Load coincident with wrap, then load held high
        slot("w_d0", 4'hE, 7'h12, 4);
        slot("w_d1", 4'hD, 7'h79, 4);
        slot("w_d2", 4'hF, 7'h7F, 4);
        slot_load("w_d3", 4'hF, 7'h7F, 16'h1234, 1'b1);
        slot("h_d0", 4'hE, 7'h19, 4);
        slot("h_d1", 4'hD, 7'h30, 4);
        slot("h_d2", 4'hB, 7'h24, 4);
        slot("h_d3", 4'h7, 7'h79, 4);

        // Mid-slot data change while load is high: new value lands one edge later
        chk("mid_c0", 4'hE, 7'h19);
        bcd = 16'h0015;
        chk("mid_c1", 4'hE, 7'h19);
        chk("mid_c2", 4'hE, 7'h12);
        load = 1'b0;
        bcd  = 16'h9999;
        chk("mid_c3", 4'hE, 7'h12);
        slot("mid_d1", 4'hD, 7'h79, 4);
        slot("mid_d2", 4'hF, 7'h7F, 4);
        slot_load("mid_d3", 4'hF, 7'h7F, 16'h1234, 1'b0);

        // Reset during the digit-2 slot
        slot("r_d0", 4'hE, 7'h19, 4);
        slot("r_d1", 4'hD, 7'h30, 4);
        slot("r_d2", 4'hB, 7'h24, 2);
        rst = 1'b1;
        slot("r_rst", 4'hF, 7'h7F, 2);
        rst = 1'b0;
        slot("r_d0_after", 4'hE, 7'h40, 4);
        slot("r_d1_after", 4'hF, 7'h7F, 4);
        slot("r_d2_after", 4'hF, 7'h7F, 4);
        slot("r_d3_after", 4'hF, 7'h7F, 4);
        slot("r_wrap", 4'hE, 7'h40, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
